// File: rtl/hdr_frame_sequencer.sv
// Owns one HDR-DDR transfer: word count from the command, per-word bit counter, optional CRC phase, done/abort pulses.
// Latency: start -> LOAD -> FRAME (2 cycles); no backpressure, counters advance only on tick and hold otherwise.
module hdr_frame_sequencer #(
    parameter int WORD_BITS = 20,
    parameter int CRC_BITS  = 10,
    parameter int CNT_W     = 17
) (
    input  logic             i_fseq_clk,
    input  logic             i_fseq_rst,
    input  logic             i_fseq_start,
    input  logic             i_fseq_abort,
    input  logic             i_fseq_tick,
    input  logic             i_regf_CMD_ATTR,
    input  logic [15:0]      i_regf_DATA_LEN,
    input  logic [2:0]       i_regf_DTT,
    input  logic             i_direct_broadcast_n,
    output logic             o_fseq_busy,
    output logic [4:0]       o_fseq_bit_count,
    output logic [CNT_W-1:0] o_fseq_words_left,
    output logic             o_fseq_word_strobe,
    output logic             o_fseq_last_frame,
    output logic             o_fseq_crc_phase,
    output logic             o_fseq_done,
    output logic             o_fseq_aborted
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FRAME,
        ST_CRC,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] words_q, words_d, load_words;
    logic             aborted_q, aborted_d;
    logic             word_end, crc_end;

    assign word_end = i_fseq_tick && (bit_cnt_q == 5'(WORD_BITS - 1));
    assign crc_end  = i_fseq_tick && (bit_cnt_q == 5'(CRC_BITS - 1));

    // Direct CCCs carry extra framing words; DTT 5..7 alias DTT 0..2.
    always_comb begin
        load_words = '0;
        if (i_regf_CMD_ATTR) begin
            case (i_regf_DTT)
                3'd0, 3'd5: load_words = CNT_W'(1);
                3'd1, 3'd6: load_words = i_direct_broadcast_n ? CNT_W'(6) : CNT_W'(2);
                3'd2, 3'd7: load_words = i_direct_broadcast_n ? CNT_W'(7) : CNT_W'(3);
                3'd3:       load_words = i_direct_broadcast_n ? CNT_W'(8) : CNT_W'(4);
                default:    load_words = i_direct_broadcast_n ? CNT_W'(9) : CNT_W'(5);
            endcase
        end else begin
            load_words = CNT_W'(i_regf_DATA_LEN)
                       + (i_direct_broadcast_n ? CNT_W'(5) : CNT_W'(1));
        end
    end

    always_comb begin
        state_d            = state_q;
        bit_cnt_d          = bit_cnt_q;
        words_d            = words_q;
        aborted_d          = 1'b0;
        o_fseq_word_strobe = 1'b0;
        o_fseq_done        = 1'b0;
        if (state_q != ST_IDLE && i_fseq_abort) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            words_d   = '0;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_fseq_start && !i_fseq_abort) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    words_d   = load_words;
                    bit_cnt_d = '0;
                    state_d   = ST_FRAME;
                end
                ST_FRAME: begin
                    if (word_end) begin
                        bit_cnt_d          = '0;
                        words_d            = words_q - CNT_W'(1);
                        o_fseq_word_strobe = 1'b1;
                        if (words_q == CNT_W'(1)) state_d = (CRC_BITS > 0) ? ST_CRC : ST_DONE;
                    end else if (i_fseq_tick) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                ST_CRC: begin
                    if (crc_end) begin
                        bit_cnt_d = '0;
                        state_d   = ST_DONE;
                    end else if (i_fseq_tick) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                ST_DONE: begin
                    o_fseq_done = 1'b1;
                    bit_cnt_d   = '0;
                    words_d     = '0;
                    state_d     = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_fseq_clk) begin
        if (i_fseq_rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            words_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            words_q   <= words_d;
            aborted_q <= aborted_d;
        end
    end

    assign o_fseq_busy       = (state_q != ST_IDLE);
    assign o_fseq_bit_count  = bit_cnt_q;
    assign o_fseq_words_left = words_q;
    assign o_fseq_last_frame = (state_q == ST_FRAME) && (words_q == CNT_W'(1));
    assign o_fseq_crc_phase  = (state_q == ST_CRC);
    assign o_fseq_aborted    = aborted_q;

endmodule
